bv_update_sched: RTL and testbench



---
 rtl/bv_update_sched.sv | 129 ++++++++++++
 tb/tb_bv_update_sched.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv_update_sched.sv
// Shares the search-engine RAMs between the key stream and table updates; keys pass through registered (1 cycle),
// updates wait for a pipeline drain, and key_req_ready drops while an update is forced, draining or executing.
module bv_update_sched #(
  parameter int DRAIN_CYCLES  = 4,
  parameter int MAX_KEY_BURST = 8,
  parameter int RD_TIMEOUT    = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_req_valid,
  input  logic [71:0] key_req,
  output logic        key_req_ready,
  output logic        key_out_valid,
  output logic [71:0] key_out,
  input  logic        upd_req_valid,
  input  logic        upd_rd_wr,
  input  logic [2:0]  upd_stage,
  input  logic [8:0]  upd_addr,
  input  logic [35:0] upd_data,
  output logic        upd_ack,
  output logic        upd_err,
  output logic [35:0] upd_rd_data,
  output logic [7:0]  set_valid,
  output logic [7:0]  read_valid,
  output logic [8:0]  ram_addr,
  output logic [35:0] ram_data,
  input  logic        eng_rd_valid,
  input  logic [35:0] eng_rd_data
);

  typedef enum logic [2:0] {RUN, DRAIN, WRITE, READ, RD_WAIT} state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0] BURST_MAX  = 8'(MAX_KEY_BURST);
  localparam logic [7:0] TO_MAX     = 8'(RD_TIMEOUT);

  state_t      state, state_nxt;
  logic [7:0]  burst_cnt;
  logic [3:0]  drain_cnt;
  logic [7:0]  to_cnt;
  logic        rd_done;
  logic [35:0] rd_data_q;
  logic        force_upd, key_accept, rd_timeout;

  assign force_upd     = upd_req_valid & (burst_cnt == BURST_MAX);
  assign key_req_ready = ~reset & (state == RUN) & ~force_upd;
  assign key_accept    = key_req_valid & key_req_ready;
  assign rd_timeout    = (state == RD_WAIT) & ~rd_done & (to_cnt == TO_MAX);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  // A key offered alongside a pending update wins until the burst limit is hit.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (upd_req_valid && (!key_req_valid || force_upd)) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = upd_rd_wr ? READ : WRITE;
      WRITE:   state_nxt = RUN;
      READ:    state_nxt = RD_WAIT;
      RD_WAIT: if (rd_done || rd_timeout) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      key_out_valid <= 1'b0;
      key_out       <= '0;
      burst_cnt     <= '0;
      drain_cnt     <= '0;
      to_cnt        <= '0;
      rd_done       <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      key_out_valid <= key_accept;
      if (key_accept) key_out <= key_req;

      if (!upd_req_valid || state_nxt != RUN) burst_cnt <= '0;
      else if (key_accept && burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 8'd1;

      drain_cnt <= (state == DRAIN) ? drain_cnt + 4'd1 : 4'd0;

      // Read data is captured here and acknowledged in the following RD_WAIT cycle.
      if (state != RD_WAIT) to_cnt <= '0;
      else if (!rd_done && !eng_rd_valid && to_cnt != TO_MAX) to_cnt <= to_cnt + 8'd1;

      rd_done <= (state == RD_WAIT) && (state_nxt == RD_WAIT) && (rd_done || eng_rd_valid);
      if (state == RD_WAIT && !rd_done && eng_rd_valid) rd_data_q <= eng_rd_data;
    end
  end

  always_comb begin
    set_valid   = '0;
    read_valid  = '0;
    ram_addr    = '0;
    ram_data    = '0;
    upd_ack     = 1'b0;
    upd_err     = 1'b0;
    upd_rd_data = '0;
    if (!reset) begin
      case (state)
        WRITE: begin
          set_valid = 8'b1 << upd_stage;
          ram_addr  = upd_addr;
          ram_data  = upd_data;
          upd_ack   = 1'b1;
        end
        READ: begin
          read_valid = 8'b1 << upd_stage;
          ram_addr   = upd_addr;
        end
        RD_WAIT: begin
          if (rd_done) begin
            upd_ack     = 1'b1;
            upd_rd_data = rd_data_q;
          end else if (rd_timeout) begin
            upd_ack = 1'b1;
            upd_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bv_update_sched.sv
// Bench for bv_update_sched: key and ack scoreboards plus per-scenario timing checks.
`timescale 1ns/1ps
module tb_bv_update_sched;
  localparam int DRAIN_CYCLES  = 4;
  localparam int MAX_KEY_BURST = 8;
  localparam int RD_TIMEOUT    = 15;

  typedef struct packed {
    logic        err;
    logic [35:0] data;
  } ack_t;

  logic        clk, reset;
  logic        key_req_valid, key_req_ready, key_out_valid;
  logic [71:0] key_req, key_out;
  logic        upd_req_valid, upd_rd_wr, upd_ack, upd_err;
  logic [2:0]  upd_stage;
  logic [8:0]  upd_addr, ram_addr;
  logic [35:0] upd_data, upd_rd_data, ram_data, eng_rd_data;
  logic [7:0]  set_valid, read_valid;
  logic        eng_rd_valid;

  logic [71:0] key_q[$];
  ack_t        ack_q[$];
  logic [71:0] kexp;
  ack_t        aexp;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_seen = 0;

  bv_update_sched #(
    .DRAIN_CYCLES(DRAIN_CYCLES), .MAX_KEY_BURST(MAX_KEY_BURST), .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .key_req_valid(key_req_valid), .key_req(key_req), .key_req_ready(key_req_ready),
    .key_out_valid(key_out_valid), .key_out(key_out),
    .upd_req_valid(upd_req_valid), .upd_rd_wr(upd_rd_wr), .upd_stage(upd_stage),
    .upd_addr(upd_addr), .upd_data(upd_data),
    .upd_ack(upd_ack), .upd_err(upd_err), .upd_rd_data(upd_rd_data),
    .set_valid(set_valid), .read_valid(read_valid), .ram_addr(ram_addr), .ram_data(ram_data),
    .eng_rd_valid(eng_rd_valid), .eng_rd_data(eng_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (!reset && key_req_valid && key_req_ready) key_q.push_back(key_req);

  always @(negedge clk) begin
    if (!reset) begin
      n_checks++;
      if ((key_out_valid && (set_valid != 8'h0 || read_valid != 8'h0)) ||
          ($countones(set_valid) + $countones(read_valid) > 1)) begin
        n_fail++;
        $display("FAIL strobe_excl: key_out_valid=%b set_valid=%h read_valid=%h", key_out_valid, set_valid, read_valid);
      end
      if (key_out_valid) begin
        n_checks++;
        if (key_q.size() == 0) begin
          n_fail++;
          $display("FAIL key_sb: unexpected key_out=%h", key_out);
        end else begin
          kexp = key_q.pop_front();
          if (key_out !== kexp) begin
            n_fail++;
            $display("FAIL key_sb: key_out=%h expected %h", key_out, kexp);
          end
        end
      end
      if (upd_ack) begin
        ack_seen++;
        n_checks++;
        if (ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_sb: unexpected upd_ack err=%b data=%h", upd_err, upd_rd_data);
        end else begin
          aexp = ack_q.pop_front();
          if (upd_err !== aexp.err || upd_rd_data !== aexp.data) begin
            n_fail++;
            $display("FAIL ack_sb: err=%b data=%h expected err=%b data=%h", upd_err, upd_rd_data, aexp.err, aexp.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; key_req_valid = 1'b0; key_req = '0; upd_req_valid = 1'b0; upd_rd_wr = 1'b0;
    upd_stage = '0; upd_addr = '0; upd_data = '0; eng_rd_valid = 1'b0; eng_rd_data = '0;
    repeat (3) tick();
    n_checks++;
    if (key_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", key_req_ready); end
    n_checks++;
    if (key_out_valid !== 1'b0 || key_out !== 72'h0) begin
      n_fail++; $display("FAIL rst_key: valid=%b key=%h want 0", key_out_valid, key_out);
    end
    n_checks++;
    if ({set_valid, read_valid, ram_addr, ram_data} !== '0) begin
      n_fail++; $display("FAIL rst_ram: set=%h read=%h addr=%h data=%h want 0", set_valid, read_valid, ram_addr, ram_data);
    end
    n_checks++;
    if ({upd_ack, upd_err, upd_rd_data} !== '0) begin
      n_fail++; $display("FAIL rst_upd: ack=%b err=%b data=%h want 0", upd_ack, upd_err, upd_rd_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_key_passthrough();
    key_req_valid = 1'b1; key_req = 72'h123456789ABCDEF012;
    settle();
    n_checks++;
    if (key_req_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready: got %b want 1", key_req_ready); end
    tick();
    key_req_valid = 1'b0;
    settle();
    n_checks++;
    if (key_out_valid !== 1'b1 || key_out !== 72'h123456789ABCDEF012) begin
      n_fail++; $display("FAIL pass_key: valid=%b key=%h want 1/123456789abcdef012", key_out_valid, key_out);
    end
    tick();
    n_checks++;
    if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_once: valid=%b want 0", key_out_valid); end
  endtask

  task automatic test_write_idle();
    int acks = 0;
    int hit = 0;
    upd_rd_wr = 1'b0; upd_stage = 3'd5; upd_addr = 9'h1A3; upd_data = 36'hF12345678; upd_req_valid = 1'b1;
    ack_q.push_back({1'b0, 36'h0});
    for (int c = 1; c <= 10; c++) begin
      tick();
      settle();
      if (upd_ack) acks++;
      if (set_valid != 8'h0) begin
        hit = 1;
        n_checks++;
        if (c != DRAIN_CYCLES + 1) begin n_fail++; $display("FAIL wr_latency: strobe at cycle %0d want %0d", c, DRAIN_CYCLES + 1); end
        n_checks++;
        if (set_valid !== 8'h20 || ram_addr !== 9'h1A3 || ram_data !== 36'hF12345678 || upd_ack !== 1'b1 || upd_err !== 1'b0) begin
          n_fail++;
          $display("FAIL wr_fields: set=%h addr=%h data=%h ack=%b err=%b want 20/1a3/f12345678/1/0", set_valid, ram_addr, ram_data, upd_ack, upd_err);
        end
        upd_req_valid = 1'b0;
      end
    end
    upd_req_valid = 1'b0;
    n_checks++;
    if (hit != 1) begin n_fail++; $display("FAIL wr_strobe: seen=%0d want 1", hit); end
    n_checks++;
    if (acks != 1) begin n_fail++; $display("FAIL wr_ack_count: got %0d want 1", acks); end
  endtask

  // The forced cycle itself accepts no key, so ready is low for it, DRAIN and WRITE.
  task automatic test_keys_plus_write();
    int acc = 0;
    int stall = 0;
    int resumed = 0;
    upd_rd_wr = 1'b0; upd_stage = 3'd1; upd_addr = 9'h00F; upd_data = 36'h5A5A5A5A5; upd_req_valid = 1'b1;
    ack_q.push_back({1'b0, 36'h0});
    for (int c = 0; c < 40 && resumed == 0; c++) begin
      key_req_valid = 1'b1;
      key_req = {8'($urandom), 32'($urandom), 32'($urandom)};
      settle();
      if (key_req_ready) begin
        if (stall == 0) acc++;
        else resumed = 1;
      end else begin
        if (stall >= 1) begin
          n_checks++;
          if (key_out_valid !== 1'b0) begin n_fail++; $display("FAIL burst_drain_key: key_out_valid=%b in stall %0d want 0", key_out_valid, stall); end
        end
        stall++;
      end
      if (upd_ack) upd_req_valid = 1'b0;
      tick();
    end
    key_req_valid = 1'b0;
    upd_req_valid = 1'b0;
    n_checks++;
    if (acc != MAX_KEY_BURST) begin n_fail++; $display("FAIL burst_keys: accepted %0d want %0d", acc, MAX_KEY_BURST); end
    n_checks++;
    if (stall != DRAIN_CYCLES + 2) begin n_fail++; $display("FAIL burst_stall: %0d cycles want %0d", stall, DRAIN_CYCLES + 2); end
    n_checks++;
    if (resumed != 1) begin n_fail++; $display("FAIL burst_resume: keys never resumed"); end
    repeat (2) tick();
  endtask

  task automatic test_read_response();
    int rcyc = -100;
    int done = 0;
    upd_rd_wr = 1'b1; upd_stage = 3'd2; upd_addr = 9'h055; upd_data = 36'h0; upd_req_valid = 1'b1;
    ack_q.push_back({1'b0, 36'h0DEADBEEF});
    for (int c = 1; c <= 40 && done == 0; c++) begin
      tick();
      eng_rd_valid = (c == 2);
      eng_rd_data = 36'($urandom);
      settle();
      if (read_valid != 8'h0) begin
        rcyc = c;
        n_checks++;
        if (read_valid !== 8'h04 || ram_addr !== 9'h055 || c != DRAIN_CYCLES + 1) begin
          n_fail++; $display("FAIL rd_strobe: read=%h addr=%h cycle=%0d want 04/055/%0d", read_valid, ram_addr, c, DRAIN_CYCLES + 1);
        end
      end
      if (c == rcyc + 3) begin eng_rd_valid = 1'b1; eng_rd_data = 36'h0DEADBEEF; end
      if (upd_ack) begin
        done = 1;
        n_checks++;
        if (c != rcyc + 4 || upd_err !== 1'b0 || upd_rd_data !== 36'h0DEADBEEF) begin
          n_fail++; $display("FAIL rd_ack: cycle=%0d err=%b data=%h want %0d/0/0deadbeef", c, upd_err, upd_rd_data, rcyc + 4);
        end
        upd_req_valid = 1'b0;
      end
    end
    eng_rd_valid = 1'b0;
    upd_req_valid = 1'b0;
    n_checks++;
    if (done != 1) begin n_fail++; $display("FAIL rd_timeout_bound: no upd_ack within 40 cycles"); end
    tick();
  endtask

  task automatic test_read_timeout();
    int rcyc = -100;
    int done = 0;
    upd_rd_wr = 1'b1; upd_stage = 3'd7; upd_addr = 9'h1FF; upd_req_valid = 1'b1;
    ack_q.push_back({1'b1, 36'h0});
    for (int c = 1; c <= 60 && done == 0; c++) begin
      tick();
      settle();
      if (read_valid != 8'h0) begin
        rcyc = c;
        n_checks++;
        if (read_valid !== 8'h80) begin n_fail++; $display("FAIL to_strobe: read=%h want 80", read_valid); end
      end
      if (upd_ack) begin
        done = 1;
        n_checks++;
        if (c != rcyc + 1 + RD_TIMEOUT || upd_err !== 1'b1 || upd_rd_data !== 36'h0) begin
          n_fail++; $display("FAIL to_ack: cycle=%0d err=%b data=%h want %0d/1/0", c, upd_err, upd_rd_data, rcyc + 1 + RD_TIMEOUT);
        end
        upd_req_valid = 1'b0;
      end
    end
    upd_req_valid = 1'b0;
    n_checks++;
    if (done != 1) begin n_fail++; $display("FAIL to_bound: no upd_ack within 60 cycles"); end
    tick();
    key_req_valid = 1'b1; key_req = 72'hA5A5_0000_1111_2222_33;
    settle();
    n_checks++;
    if (key_req_ready !== 1'b1) begin n_fail++; $display("FAIL to_keys: key_req_ready=%b want 1", key_req_ready); end
    tick();
    key_req_valid = 1'b0;
    settle();
    n_checks++;
    if (key_out_valid !== 1'b1) begin n_fail++; $display("FAIL to_key_out: key_out_valid=%b want 1", key_out_valid); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int rcyc = -1;
    int acks_before;
    upd_rd_wr = 1'b1; upd_stage = 3'd3; upd_addr = 9'h0C0; upd_req_valid = 1'b1;
    for (int c = 1; c <= 20 && rcyc < 0; c++) begin
      tick();
      settle();
      if (read_valid != 8'h0) rcyc = c;
    end
    n_checks++;
    if (rcyc < 0) begin n_fail++; $display("FAIL rst_mid_read: read strobe not seen within 20 cycles"); end
    repeat (2) tick();
    acks_before = ack_seen;
    reset = 1'b1;
    upd_req_valid = 1'b0;
    tick();
    settle();
    n_checks++;
    if ({key_req_ready, key_out_valid, key_out, set_valid, read_valid, ram_addr, ram_data, upd_ack, upd_err, upd_rd_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_out: ready=%b kv=%b set=%h read=%h ack=%b err=%b rd=%h want all 0", key_req_ready, key_out_valid, set_valid, read_valid, upd_ack, upd_err, upd_rd_data);
    end
    tick();
    reset = 1'b0;
    key_req_valid = 1'b1; key_req = 72'h0F0E0D0C0B0A090807;
    settle();
    n_checks++;
    if (key_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: key_req_ready=%b want 1", key_req_ready); end
    tick();
    key_req_valid = 1'b0;
    settle();
    n_checks++;
    if (key_out_valid !== 1'b1 || ack_seen != acks_before) begin
      n_fail++; $display("FAIL rst_mid_after: key_out_valid=%b acks=%0d want 1/%0d", key_out_valid, ack_seen, acks_before);
    end
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_key_passthrough();
    test_write_idle();
    test_keys_plus_write();
    test_read_response();
    test_read_timeout();
    test_reset_mid_op();
    n_checks++;
    if (key_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: keys left=%0d acks left=%0d want 0/0", key_q.size(), ack_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
